// File: rtl/mem_req_adapter_pkg.sv
// mem_req_adapter_pkg: shared LC-3b memory-port types and adapter FSM states
package mem_req_adapter_pkg;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;
    typedef enum logic [1:0] {IDLE, REQ, RESP} lc3b_memadapt_state;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts REQ cycles without ack and flags the last allowed one
module mem_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    // clear dominates so every REQ entry starts from zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (inc) cnt <= cnt + W'(1);
    assign expired = inc && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/mem_req_adapter.sv
// mem_req_adapter: CPU level-held mem_read/mem_write to pmem req/ack; optional MEM_TIMEOUT_EN abort
module mem_req_adapter
    import mem_req_adapter_pkg::*;
#(
    parameter int       TIMEOUT_CYCLES = 255,
    parameter lc3b_word ERR_RDATA      = 16'hDEAD
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,
    output logic          mem_error,
    output logic          pmem_req,
    output logic          pmem_we,
    output lc3b_mem_wmask pmem_be,
    output lc3b_word      pmem_addr,
    output lc3b_word      pmem_wdata,
    input  logic          pmem_ack,
    input  lc3b_word      pmem_rdata
);
    lc3b_memadapt_state state;
`ifdef MEM_TIMEOUT_EN
    logic expired;
    mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_ctr (
        .clk(clk),
        .rst_n(rst_n),
        .clear(state != REQ),
        .inc(state == REQ && !pmem_ack),
        .expired(expired)
    );
`else
    logic unused_params;
    assign unused_params = ^{TIMEOUT_CYCLES, ERR_RDATA};
`endif
    // adapter FSM; pmem_* outputs double as the capture registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            mem_resp   <= 1'b0;
            mem_rdata  <= '0;
            mem_error  <= 1'b0;
            pmem_req   <= 1'b0;
            pmem_we    <= 1'b0;
            pmem_be    <= '0;
            pmem_addr  <= '0;
            pmem_wdata <= '0;
        end else begin
            mem_resp <= 1'b0;
            case (state)
                IDLE:
                    if (mem_write) begin
                        pmem_we    <= 1'b1;
                        pmem_be    <= mem_byte_enable;
                        pmem_addr  <= {mem_address[15:1], 1'b0};
                        pmem_wdata <= mem_wdata;
                        if (mem_byte_enable == 2'b00) begin
                            state    <= RESP;
                            mem_resp <= 1'b1;
                        end else begin
                            state    <= REQ;
                            pmem_req <= 1'b1;
                        end
                    end else if (mem_read) begin
                        pmem_we   <= 1'b0;
                        pmem_be   <= 2'b11;
                        pmem_addr <= {mem_address[15:1], 1'b0};
                        state     <= REQ;
                        pmem_req  <= 1'b1;
                    end
                REQ:
                    if (pmem_ack) begin
                        if (!pmem_we) mem_rdata <= pmem_rdata;
                        pmem_req <= 1'b0;
                        mem_resp <= 1'b1;
                        state    <= RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (expired) begin
                        if (!pmem_we) mem_rdata <= ERR_RDATA;
                        mem_error <= 1'b1;
                        pmem_req  <= 1'b0;
                        mem_resp  <= 1'b1;
                        state     <= RESP;
                    end
`endif
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_mem_req_adapter.sv
// tb_mem_req_adapter: directed vectors with a response scoreboard
module tb_mem_req_adapter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [1:0]  mem_byte_enable = 2'b00;
    logic [15:0] mem_address = '0, mem_wdata = '0;
    logic        mem_resp, mem_error, pmem_req, pmem_we;
    logic [15:0] mem_rdata, pmem_addr, pmem_wdata;
    logic [1:0]  pmem_be;
    logic        pmem_ack = 1'b0;
    logic [15:0] pmem_rdata = '0;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } exp_t;
    exp_t sbq[$];
    int   vecs = 0;
    int   errs = 0;

    mem_req_adapter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(16'hDEAD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_resp(mem_resp),
        .mem_rdata(mem_rdata),
        .mem_error(mem_error),
        .pmem_req(pmem_req),
        .pmem_we(pmem_we),
        .pmem_be(pmem_be),
        .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata),
        .pmem_ack(pmem_ack),
        .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    // monitor: every mem_resp pulse must match the oldest expected response
    always @(negedge clk) begin
        if (rst_n && mem_resp) begin
            vecs++;
            if (sbq.size() == 0) begin
                errs++;
                $display("FAIL resp_unexpected: got mem_resp with rdata %h, none expected", mem_rdata);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (mem_rdata !== e.rdata || mem_error !== e.err) begin
                    errs++;
                    $display("FAIL resp_data: got rdata %h err %b, want rdata %h err %b",
                             mem_rdata, mem_error, e.rdata, e.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic [15:0] rd, input logic er);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        sbq.push_back(e);
    endtask

    initial begin
        logic [15:0] cur_rdata;
        cur_rdata = 16'h0000;
        #2;
        chk("rst_pmem_req", {15'd0, pmem_req}, 16'd0);
        chk("rst_mem_resp", {15'd0, mem_resp}, 16'd0);
        chk("rst_rdata", mem_rdata, 16'h0000);
        chk("rst_error", {15'd0, mem_error}, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // read, ack in first REQ cycle
        mem_read = 1'b1; mem_address = 16'h3001;
        tick();
        chk("rd_req", {15'd0, pmem_req}, 16'd1);
        chk("rd_addr", pmem_addr, 16'h3000);
        chk("rd_be", {14'd0, pmem_be}, 16'h0003);
        chk("rd_we", {15'd0, pmem_we}, 16'd0);
        pmem_ack = 1'b1; pmem_rdata = 16'h1234;
        expect_resp(16'h1234, 1'b0);
        cur_rdata = 16'h1234;
        tick();
        chk("rd_resp_cyc2", {15'd0, mem_resp}, 16'd1);
        chk("rd_req_drop", {15'd0, pmem_req}, 16'd0);
        pmem_ack = 1'b0; mem_read = 1'b0;
        tick();
        chk("rd_resp_pulse", {15'd0, mem_resp}, 16'd0);

        // stray ack in IDLE is ignored
        pmem_ack = 1'b1; pmem_rdata = 16'hFFFF;
        tick();
        pmem_ack = 1'b0;
        chk("idle_ack_req", {15'd0, pmem_req}, 16'd0);
        tick();
        chk("idle_ack_resp", {15'd0, mem_resp}, 16'd0);

        // write, ack after 3 REQ cycles
        mem_write = 1'b1; mem_byte_enable = 2'b10; mem_wdata = 16'hAB00; mem_address = 16'h0040;
        tick();
        mem_wdata = 16'h5555; mem_address = 16'h7777; mem_byte_enable = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            chk("wr_req", {15'd0, pmem_req}, 16'd1);
            chk("wr_we", {15'd0, pmem_we}, 16'd1);
            chk("wr_be", {14'd0, pmem_be}, 16'h0002);
            chk("wr_wdata", pmem_wdata, 16'hAB00);
            chk("wr_addr", pmem_addr, 16'h0040);
            if (i == 3) begin
                pmem_ack = 1'b1; pmem_rdata = 16'hBEEF;
                expect_resp(cur_rdata, 1'b0);
            end
            tick();
        end
        chk("wr_resp", {15'd0, mem_resp}, 16'd1);
        pmem_ack = 1'b0; mem_write = 1'b0;
        tick();
        chk("wr_resp_pulse", {15'd0, mem_resp}, 16'd0);

        // zero-mask write: resp next cycle, no pmem access
        mem_write = 1'b1; mem_byte_enable = 2'b00; mem_wdata = 16'h1111; mem_address = 16'h0100;
        expect_resp(cur_rdata, 1'b0);
        tick();
        chk("zm_resp", {15'd0, mem_resp}, 16'd1);
        chk("zm_no_req", {15'd0, pmem_req}, 16'd0);
        mem_write = 1'b0;
        tick();
        chk("zm_no_req2", {15'd0, pmem_req}, 16'd0);

        // read and write together: write wins
        mem_read = 1'b1; mem_write = 1'b1; mem_byte_enable = 2'b01;
        mem_wdata = 16'h00CD; mem_address = 16'h0051;
        tick();
        chk("both_we", {15'd0, pmem_we}, 16'd1);
        chk("both_be", {14'd0, pmem_be}, 16'h0001);
        chk("both_addr", pmem_addr, 16'h0050);
        chk("both_wdata", pmem_wdata, 16'h00CD);
        pmem_ack = 1'b1; pmem_rdata = 16'h9999;
        expect_resp(cur_rdata, 1'b0);
        tick();
        pmem_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        tick();

        // back-to-back: read held one cycle past resp
        mem_read = 1'b1; mem_address = 16'h2222;
        tick();
        pmem_ack = 1'b1; pmem_rdata = 16'hA5A5;
        expect_resp(16'hA5A5, 1'b0);
        tick();
        pmem_ack = 1'b0;
        chk("b2b_resp1", {15'd0, mem_resp}, 16'd1);
        tick();
        chk("b2b_gap_req", {15'd0, pmem_req}, 16'd0);
        chk("b2b_gap_resp", {15'd0, mem_resp}, 16'd0);
        tick();
        mem_read = 1'b0;
        chk("b2b_req2", {15'd0, pmem_req}, 16'd1);
        pmem_ack = 1'b1; pmem_rdata = 16'h5A5A;
        expect_resp(16'h5A5A, 1'b0);
        cur_rdata = 16'h5A5A;
        tick();
        pmem_ack = 1'b0;
        chk("b2b_resp2", {15'd0, mem_resp}, 16'd1);
        tick();

        // reset mid-REQ
        mem_read = 1'b1; mem_address = 16'h4444;
        tick();
        chk("rstm_req_before", {15'd0, pmem_req}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rstm_req", {15'd0, pmem_req}, 16'd0);
        chk("rstm_resp", {15'd0, mem_resp}, 16'd0);
        chk("rstm_rdata", mem_rdata, 16'h0000);
        cur_rdata = 16'h0000;
        mem_read = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("rstm_no_req", {15'd0, pmem_req}, 16'd0);

`ifdef MEM_TIMEOUT_EN
        // timeout: no ack, abort after 4 REQ cycles
        mem_read = 1'b1; mem_address = 16'h0600;
        tick();
        mem_read = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("to_req_held", {15'd0, pmem_req}, 16'd1);
            if (i == 4) expect_resp(16'hDEAD, 1'b1);
            tick();
        end
        chk("to_req_drop", {15'd0, pmem_req}, 16'd0);
        chk("to_resp", {15'd0, mem_resp}, 16'd1);
        tick();
        tick();
        chk("to_err_sticky", {15'd0, mem_error}, 16'd1);
`endif

        tick();
        chk("sb_drained", 16'(sbq.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
